uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
Receive-side framer for the UART link. It consumes the byte strobes from the UART receiver (`received`, `rx_byte`, `recv_error`) and parses framed host commands. Each valid frame is assembled into a parallel payload word and presented to the compute block over a valid/ready handshake. It is the inbound counterpart of the outbound result path, which drives `tx_byte`/`transmit`.

Parameters:
- MAX_LEN, 4: maximum payload bytes per frame; payload bus is 8*MAX_LEN bits.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 60000: max clk cycles between bytes inside a frame (5 ms at 12 MHz, about 4.8 byte times at 9600 baud).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, byte received (UART `received`).
- rx_byte  in  8  received byte, valid with rx_valid.
- rx_error  in  1  one-cycle strobe, UART framing error (`recv_error`).
- frame_data  out  8*MAX_LEN  payload; byte 0 in [7:0], unused upper bytes zero.
- frame_len  out  8  payload byte count of the held frame.
- frame_valid  out  1  frame held, stable until accepted.
- frame_ready  in  1  consumer accepts when frame_valid&&frame_ready.
- err_pulse  out  1  one-cycle pulse on any discarded frame.
- err_code  out  2  cause of last error: 0 bad length, 1 checksum, 2 timeout/rx_error, 3 overrun.
- good_cnt  out  16  frames delivered (see Optional Feature).
- bad_cnt  out  16  frames discarded (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; frame_data=0, frame_len=0, frame_valid=0, err_pulse=0, err_code=0, good_cnt=0, bad_cnt=0; timeout counter and checksum accumulator cleared.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK. CHK must equal LEN XOR each payload byte.
- State IDLE:
  - rx_valid with byte==SYNC_BYTE: go to LEN.
  - Any other byte: ignored silently.
  - rx_error: ignored.
- State LEN:
  - LEN in 1..MAX_LEN: store it, set acc=LEN, index=0, clear the shadow payload register, go to PAYLOAD.
  - LEN of 0 or >MAX_LEN: error code 0, go to IDLE.
- State PAYLOAD:
  - Each byte is written to shadow byte[index] and XORed into acc; index increments.
  - After byte LEN-1: go to CHK.
- State CHK:
  - byte==acc: complete the frame.
  - Otherwise: error code 1.
  - Either way, go to IDLE.
- Complete:
  - Cycle after the CHK strobe: frame_data←shadow, frame_len←LEN, frame_valid=1, good_cnt++.
  - If frame_valid=1 and frame_ready=0 at completion: the new frame is dropped, the held frame is unchanged, error code 3.
  - If frame_ready=1 in that same cycle: the old frame is consumed and the new one loads (no overrun).
- Handshake:
  - frame_valid falls the cycle after frame_valid&&frame_ready.
  - frame_data and frame_len are stable while frame_valid=1.
- Timeout:
  - Counter runs only in LEN/PAYLOAD/CHK and is cleared on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 without a byte: error code 2, go to IDLE.
- rx_error outside IDLE: error code 2, go to IDLE; a simultaneous rx_valid byte is discarded.
- Error:
  - err_pulse=1 for exactly one cycle, err_code updated and held until the next error, bad_cnt++.
  - Parser returns to IDLE; a SYNC byte arriving in the next strobe starts a new frame.
- Counters saturate at 16'hFFFF.
- Reset mid-frame discards all partial state immediately; the held output frame is lost.

Optional Feature:
- Macro FRAME_STATS_EN.
- Defined: good_cnt/bad_cnt count as specified.
- Undefined: both ports tied to 16'h0000 and no counter registers are synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Good frame: A5 02 11 22 CHK=31, frame_ready=1 → frame_valid pulses one cycle with frame_data=32'h00002211, frame_len=2, good_cnt=1, no err_pulse.
- Bad checksum: A5 01 7E 00 → no frame_valid; err_pulse once, err_code=1, bad_cnt=1. Following A5 01 7E 7F → delivered with frame_data=32'h0000007E.
- Bad length: A5 05 (MAX_LEN=4) → err_code=0. Next bytes 33 44 ignored. A5 00 → err_code=0 again, bad_cnt=2.
- Timeout/rx_error: A5 03 AA then silence for TIMEOUT_CYCLES → err_code=2, back to IDLE. Then A5 02 with rx_error strobe → err_code=2, nothing delivered.
- Overrun/backpressure: hold frame_ready=0, send two good frames → first held unchanged, second dropped with err_code=3. Then raise frame_ready in the same cycle a third frame completes → third loads, no error.
- Reset: assert rst_n=0 after A5 02 11 → all outputs zero. After release, a complete good frame is delivered normally. With FRAME_STATS_EN undefined, good_cnt and bad_cnt read 0 throughout.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Parses SYNC,LEN,payload,CHK frames from UART byte strobes; frame presented 1 cycle after CHK strobe.
// Held frame waits for frame_ready; a new frame arriving while blocked is dropped (overrun). FRAME_STATS_EN enables good/bad counters.
module uart_frame_rx #(
    parameter int         MAX_LEN        = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 60000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_error,
    output logic [8*MAX_LEN-1:0]   frame_data,
    output logic [7:0]             frame_len,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   err_pulse,
    output logic [1:0]             err_code,
    output logic [15:0]            good_cnt,
    output logic [15:0]            bad_cnt
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t                 state_q;
    logic [7:0]             len_q;
    logic [7:0]             idx_q;
    logic [7:0]             acc_q;
    logic [8*MAX_LEN-1:0]   shadow_q;
    logic [TW-1:0]          tmo_q;
    logic [8*MAX_LEN-1:0]   frame_data_q;
    logic [7:0]             frame_len_q;
    logic                   frame_valid_q;
    logic                   err_pulse_q;
    logic [1:0]             err_code_q;

    logic       len_ok, tmo_hit, abort, chk_done, chk_good, overrun, load;
    logic       err_ev;
    logic [1:0] err_cd;

    always_comb begin
        len_ok   = (rx_byte != 8'd0) && (rx_byte <= MAX_LEN_B);
        tmo_hit  = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
        abort    = (state_q != S_IDLE) && (rx_error || tmo_hit);
        chk_done = (state_q == S_CHK) && rx_valid && !rx_error;
        chk_good = chk_done && (rx_byte == acc_q);
        // A consumer accepting in the completion cycle frees the slot, so no overrun.
        overrun  = chk_good && frame_valid_q && !frame_ready;
        load     = chk_good && !overrun;
        err_ev   = 1'b0;
        err_cd   = 2'd0;
        if (abort) begin
            err_ev = 1'b1;
            err_cd = 2'd2;
        end else if ((state_q == S_LEN) && rx_valid && !len_ok) begin
            err_ev = 1'b1;
            err_cd = 2'd0;
        end else if (chk_done && !chk_good) begin
            err_ev = 1'b1;
            err_cd = 2'd1;
        end else if (overrun) begin
            err_ev = 1'b1;
            err_cd = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= 8'd0;
            idx_q         <= 8'd0;
            acc_q         <= 8'd0;
            shadow_q      <= '0;
            tmo_q         <= '0;
            frame_data_q  <= '0;
            frame_len_q   <= 8'd0;
            frame_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            err_pulse_q <= err_ev;
            if (err_ev) begin
                err_code_q <= err_cd;
            end

            if (load) begin
                frame_data_q  <= shadow_q;
                frame_len_q   <= len_q;
                frame_valid_q <= 1'b1;
            end else if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
            end

            if ((state_q == S_IDLE) || rx_valid) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (abort) begin
                state_q <= S_IDLE;
            end else if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (len_ok) begin
                            len_q    <= rx_byte;
                            acc_q    <= rx_byte;
                            idx_q    <= 8'd0;
                            shadow_q <= '0;
                            state_q  <= S_PAYLOAD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_PAYLOAD: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx_q == 8'(i)) begin
                                shadow_q[i*8 +: 8] <= rx_byte;
                            end
                        end
                        acc_q <= acc_q ^ rx_byte;
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == 8'(len_q - 8'd1)) begin
                            state_q <= S_CHK;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_len   = frame_len_q;
    assign frame_valid = frame_valid_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;

`ifdef FRAME_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] bad_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= 16'd0;
            bad_cnt_q  <= 16'd0;
        end else begin
            if (load && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (err_ev && (bad_cnt_q != 16'hFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`else
    assign good_cnt = 16'h0000;
    assign bad_cnt  = 16'h0000;
`endif

endmodule
